// File: rtl/toggle_activity_monitor.sv
// ---------------------------------------------------------------------------
// toggle_activity_monitor
//
// Counts switching activity on a bundle of monitored signals over a
// programmable window of clock cycles. The block keeps a per-signal toggle
// count and a window total, and offers them through a valid/ready handshake.
//
// Ports
//   clk           rising-edge clock (the only clock)
//   rst_n         asynchronous active-low reset
//   start         single-cycle request to open a window (honoured in IDLE
//                 only, and only when win_len is nonzero)
//   win_len       number of compare cycles in the window, sampled with start
//   clear         synchronous abort: back to IDLE with every counter zeroed
//   sig_in        monitored signals, synchronous to clk
//   busy          high whenever the monitor is not idle
//   out_valid     results available (HOLD state)
//   out_ready     consumer accepts the results
//   toggle_cnt    per-signal counts, signal i at [i*CNT_W +: CNT_W]
//   toggle_total  total toggles seen in the window
// ---------------------------------------------------------------------------
module toggle_activity_monitor #(
    parameter int NSIG  = 4,
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WIN_W-1:0]        win_len,
    input  logic                    clear,
    input  logic [NSIG-1:0]         sig_in,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NSIG*CNT_W-1:0]   toggle_cnt,
    output logic [CNT_W+3:0]        toggle_total
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [NSIG-1:0]    prev;
    logic [WIN_W-1:0]   remaining;
    logic [CNT_W-1:0]   cnt [NSIG];
    logic [CNT_W+3:0]   total;

    logic               launch;
    logic [NSIG-1:0]    toggles;
    logic [4:0]         pop;
    logic [CNT_W-1:0]   cnt_inc [NSIG];
    logic [CNT_W+4:0]   total_sum;
    logic [CNT_W+3:0]   total_inc;

    // A window only opens for a nonzero length; a zero-length start is
    // treated as if start had never been asserted.
    assign launch = start && (win_len != '0);

    // State register. Reset is asynchronous so busy/out_valid fall
    // immediately when rst_n drops, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. clear overrides everything, including the start
    // request and the output handshake. start is only looked at in IDLE.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (launch) state_next = COUNT;
                COUNT:   if (remaining == WIN_W'(1)) state_next = HOLD;
                HOLD:    if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Per-cycle increment values. Each per-signal counter sticks at its
    // maximum; the total is saturated on its own, so once a signal counter
    // has saturated the total may legitimately exceed the sum of the
    // per-signal counts. The sum is formed one bit wider than the total so
    // the carry out can be used as the overflow flag.
    always_comb begin
        toggles = sig_in ^ prev;
        pop     = '0;
        for (int i = 0; i < NSIG; i++) begin
            pop        = pop + 5'(toggles[i]);
            cnt_inc[i] = (toggles[i] && (cnt[i] != '1)) ? cnt[i] + CNT_W'(1) : cnt[i];
        end
        total_sum = {1'b0, total} + (CNT_W+5)'(pop);
        total_inc = total_sum[CNT_W+4] ? '1 : total_sum[CNT_W+3:0];
    end

    // Datapath registers. In IDLE a launch takes the baseline sample and
    // zeroes the counters; the counters otherwise keep the last window's
    // results so they stay readable after the handshake. In COUNT every
    // cycle compares against the previous sample and counts down the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= '0;
            remaining <= '0;
            total     <= '0;
            for (int i = 0; i < NSIG; i++) cnt[i] <= '0;
        end else if (clear) begin
            prev      <= '0;
            remaining <= '0;
            total     <= '0;
            for (int i = 0; i < NSIG; i++) cnt[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        prev      <= sig_in;
                        remaining <= win_len;
                        total     <= '0;
                        for (int i = 0; i < NSIG; i++) cnt[i] <= '0;
                    end
                end
                COUNT: begin
                    prev      <= sig_in;
                    remaining <= remaining - WIN_W'(1);
                    total     <= total_inc;
                    for (int i = 0; i < NSIG; i++) cnt[i] <= cnt_inc[i];
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs come straight from registers; there is no path from sig_in.
    always_comb begin
        toggle_cnt = '0;
        for (int i = 0; i < NSIG; i++) begin
            toggle_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

    assign toggle_total = total;
    assign busy         = (state != IDLE);
    assign out_valid    = (state == HOLD);

endmodule
